uart_tx_sched: RTL
==================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter DBIT, default 8, data bits per frame (5..8).
REQ-002 SHALL have parameter SB_TICK, default 16, s_tick count for stop bit (16 = 1 stop bit, 32 = 2 stop bits).
REQ-003 SHALL have port clk_100MHz  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port s_tick  input  1  one-cycle 16x-oversample baud tick from the team's baud tick generator.
REQ-006 SHALL have ports valid0, valid1  input  1 each  requester has a byte pending.
REQ-007 SHALL have ports din0, din1  input  DBIT each  requester byte, LSB first on line.
REQ-008 SHALL have ports ready0, ready1  output  1 each  one-cycle accept pulse; byte is taken when validX and readyX are both high.
REQ-009 SHALL have port tx  output  1  serial line, idle high.
REQ-010 SHALL have port busy  output  1  high while a frame is in progress.
REQ-011 SHALL have port src  output  1  index of the requester owning the current or last frame.
REQ-012 SHALL have port tx_done_tick  output  1  one-cycle pulse at end of stop bit.

Function
REQ-013 SHALL implement the FSM IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE; all outputs registered.
REQ-014 IDLE: if any validX is high, SHALL grant one requester, latch its din into the shift register, pulse its readyX for exactly 1 cycle, set src, and enter START on the next cycle.
REQ-015 Arbitration SHALL be round-robin: when both are valid, the requester selected by pointer ptr wins; after every grant, ptr SHALL point to the other requester.
REQ-016 START: tx=0 until 16 s_ticks have been counted (s_cnt 0..15), then DATA with s_cnt=0 and bit index n=0.
REQ-017 DATA: tx=shreg[0]; at the 16th s_tick, shift right and increment n; after bit DBIT-1, go to PARITY if configured, else STOP.
REQ-018 STOP: tx=1 for SB_TICK s_ticks; on the last one, pulse tx_done_tick, enter IDLE, and deassert busy in the same cycle.
REQ-019 An s_tick in the acceptance cycle SHALL NOT be counted; counting starts the first cycle in START.
REQ-020 s_tick SHALL be ignored in IDLE; validX SHALL be ignored while busy (readyX stays low).
REQ-021 A back-to-back frame SHALL be possible: valid in the tx_done_tick cycle is sampled in the following IDLE cycle, giving a 1-cycle idle gap minimum.
REQ-022 Frame length SHALL be exactly 16*(1+DBIT[+1])+SB_TICK s_ticks.

Reset
REQ-023 On rst: state=IDLE, tx=1, busy=0, ready0=ready1=0, tx_done_tick=0, src=0, ptr=0, s_cnt=0, n=0.
REQ-024 rst mid-frame SHALL abort: tx=1 from the next cycle, the latched byte is discarded, and no tx_done_tick is issued.

Configuration
REQ-025 With UART_TX_PARITY_EN defined, the PARITY state SHALL send the even parity of the DBIT data bits for 16 s_ticks.
REQ-026 Without UART_TX_PARITY_EN, there SHALL be no PARITY state or parity logic; DATA goes directly to STOP.

Structure
REQ-027 Package uart_pkg SHALL hold the state enumeration typedef, OVERSAMPLE=16, and the DBIT/SB_TICK defaults.
REQ-028 The round-robin arbiter SHALL be sub-module rr_arb2 (inputs valid0/1, ptr; output grant, grant index); the FSM, counters and shift register stay in uart_tx_sched.

Verification
REQ-029 valid0=1, din0=8'hA5 only -> ready0 pulse 1 cycle, src=0; tx pattern 0,1,0,1,0,0,1,0,1,1, each 16 ticks; tx_done_tick after 160 ticks.
REQ-030 valid0 and valid1 both high continuously, ptr=0 after reset -> grants alternate 0,1,0,1 across four frames; each frame is separated by exactly 1 idle cycle.
REQ-031 rst asserted at s_tick 70 of a frame -> tx=1, busy=0 next cycle, no tx_done_tick; next valid1 is granted normally.
REQ-032 s_tick coincident with the acceptance cycle -> start bit still lasts 16 counted ticks; a glitch-free tx during IDLE under continuous s_tick.
REQ-033 UART_TX_PARITY_EN defined, din0=8'h07 -> parity bit=1 after bit 7; frame is 176 ticks; SB_TICK=32 -> stop high for 32 ticks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the scheduled UART transmitter.
// Holds the FSM state type, oversample ratio and parameter defaults.
package uart_pkg;

  localparam int OVERSAMPLE      = 16;
  localparam int DBIT_DEFAULT    = 8;
  localparam int SB_TICK_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Two-requester byte handshake into the UART scheduler.
// master: requester side (valid/din out); slave: scheduler side.
interface uart_tx_sched_if
  import uart_pkg::*;
#(
  parameter int DBIT = DBIT_DEFAULT
);
  logic            valid0;
  logic            valid1;
  logic [DBIT-1:0] din0;
  logic [DBIT-1:0] din1;
  logic            ready0;
  logic            ready1;

  modport master (
    output valid0, valid1, din0, din1,
    input  ready0, ready1
  );

  modport slave (
    input  valid0, valid1, din0, din1,
    output ready0, ready1
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: ptr breaks ties when both request.
// In: valid0, valid1, ptr. Out: grant (any), grant_idx (winner).
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic ptr,
  output logic grant,
  output logic grant_idx
);
  assign grant     = valid0 | valid1;
  assign grant_idx = (valid0 & valid1) ? ptr : valid1;
endmodule

// File: rtl/uart_tx_sched.sv
// UART transmitter fed by two requesters via round-robin arbitration.
// Ports: clk_100MHz, rst (sync, high), s_tick (16x baud), req
// (uart_tx_sched_if.slave), tx, busy, src, tx_done_tick.
// Define UART_TX_PARITY_EN to append an even parity bit.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEFAULT,
  parameter int SB_TICK = SB_TICK_DEFAULT
) (
  input  logic               clk_100MHz,
  input  logic               rst,
  input  logic               s_tick,
  uart_tx_sched_if.slave     req,
  output logic               tx,
  output logic               busy,
  output logic               src,
  output logic               tx_done_tick
);
  localparam int CMAX =
    (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
  localparam int CW = $clog2(CMAX);
  localparam int NW = $clog2(DBIT);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] sh_q, sh_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic [1:0]      rdy_q, rdy_d;
  logic            src_q, src_d;
  logic            ptr_q, ptr_d;
  logic            done_q, done_d;
  logic            grant, gidx;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  rr_arb2 u_arb (
    .valid0    (req.valid0),
    .valid1    (req.valid1),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (gidx)
  );

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      rdy_q   <= 2'b00;
      src_q   <= 1'b0;
      ptr_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    sh_d    = sh_q;
    busy_d  = busy_q;
    rdy_d   = 2'b00;
    src_d   = src_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        // s_tick is ignored here, so a tick in the
        // grant cycle never shortens the start bit.
        if (grant) begin
          state_d = START;
          cnt_d   = '0;
          n_d     = '0;
          sh_d    = gidx ? req.din1 : req.din0;
          busy_d  = 1'b1;
          rdy_d   = gidx ? 2'b10 : 2'b01;
          src_d   = gidx;
          ptr_d   = ~gidx;
`ifdef UART_TX_PARITY_EN
          par_d   = ^sh_d;
`endif
        end
      end
      START: begin
        if (s_tick) begin
          if (cnt_q == CW'(OVERSAMPLE - 1)) begin
            state_d = DATA;
            cnt_d   = '0;
            n_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (cnt_q == CW'(OVERSAMPLE - 1)) begin
            cnt_d = '0;
            sh_d  = sh_q >> 1;
            if (n_q == NW'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (cnt_q == CW'(OVERSAMPLE - 1)) begin
            state_d = STOP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (cnt_q == CW'(SB_TICK - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the state being entered,
    // so tx stays aligned with the registered state.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  assign tx           = tx_q;
  assign busy         = busy_q;
  assign src          = src_q;
  assign tx_done_tick = done_q;
  assign req.ready0   = rdy_q[0];
  assign req.ready1   = rdy_q[1];

endmodule
